// File: rtl/logic_op_sequencer.sv
// Switch-driven logic-gate sequencer: one operation at a time on LD0-LD3.
// A debounced button or an auto-dwell timer steps NOT -> OR -> XOR -> OR3.
module logic_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DWELL_CYCLES    = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       btn,
  input  logic       auto,
  output logic [3:0] led,
  output logic [1:0] op_sel,
  output logic       step
);

  typedef enum logic [1:0] {
    OP_NOT = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_OR3 = 2'd3
  } op_e;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  logic [4:0]      sync1_q, sync1_d;
  logic [4:0]      sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic            stable_prev_q, stable_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            step_q, step_d;
  logic [3:0]      led_q, led_d;
  op_e             state_q, state_d;

  logic [2:0] sw_sync;
  logic       btn_sync;
  logic       auto_sync;
  logic       press;
  logic       dwell_done;
  logic       result;

  assign sw_sync   = sync2_q[2:0];
  assign btn_sync  = sync2_q[3];
  assign auto_sync = sync2_q[4];

  // Datapath registers: synchronizers, debounce, dwell timer, step, led
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      dwell_q       <= '0;
      step_q        <= 1'b0;
      led_q         <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      db_cnt_q      <= db_cnt_d;
      dwell_q       <= dwell_d;
      step_q        <= step_d;
      led_q         <= led_d;
    end
  end

  // Synchronize, debounce the button, time the dwell and merge step sources
  always_comb begin
    sync1_d       = {auto, btn, sw};
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    db_cnt_d      = '0;
    stable_prev_d = stable_q;
    if (btn_sync != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = btn_sync;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press      = stable_q & ~stable_prev_q;
    dwell_done = auto_sync && (dwell_q == DW_LAST);
    if (!auto_sync || press || dwell_done) begin
      dwell_d = '0;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
    step_d = press | dwell_done;
  end

  // Selected gate result, shown one-hot on that operation's LED
  always_comb begin
    result = 1'b0;
    unique case (state_q)
      OP_NOT: result = ~sw_sync[0];
      OP_OR:  result = sw_sync[0] | sw_sync[1];
      OP_XOR: result = sw_sync[0] ^ sw_sync[1];
      OP_OR3: result = |sw_sync;
    endcase
    led_d          = '0;
    led_d[state_q] = result;
  end

  // Operation state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OP_NOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next operation on each step, wrapping OR3 back to NOT
  always_comb begin
    state_d = state_q;
    if (step_q) begin
      unique case (state_q)
        OP_NOT: state_d = OP_OR;
        OP_OR:  state_d = OP_XOR;
        OP_XOR: state_d = OP_OR3;
        OP_OR3: state_d = OP_NOT;
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    op_sel = state_q;
    led    = led_q;
    step   = step_q;
  end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: per-cycle model compare plus
// hand-computed directed expectations.
module tb_logic_op_sequencer;

  localparam int DEB = 4;
  localparam int DWL = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw = 3'd0;
  logic       btn = 1'b0;
  logic       auto = 1'b0;
  logic [3:0] led;
  logic [1:0] op_sel;
  logic       step;

  int nchecks = 0;
  int nfail   = 0;
  int n_steps = 0;
  bit chk_en  = 1'b0;
  logic prev_step = 1'b0;

  logic_op_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWL)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .sw    (sw),
    .btn   (btn),
    .auto  (auto),
    .led   (led),
    .op_sel(op_sel),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic gate(input logic [1:0] op, input logic [2:0] s);
    case (op)
      2'd0:    return !s[0];
      2'd1:    return s[0] | s[1];
      2'd2:    return s[0] ^ s[1];
      default: return |s;
    endcase
  endfunction

  // Behavioural model: inputs seen two edges late, button accepted after
  // DEB consecutive differing samples, a step one cycle after acceptance
  // of a rise or after a full dwell, operation advancing on the step.
  logic [4:0] m_s1, m_s2;
  logic       m_stable, m_stable_old, m_step;
  int         m_run, m_dwell;
  logic [1:0] m_op;
  logic [3:0] m_led;
  logic       m_press, m_expire;

  assign m_press  = m_stable && !m_stable_old;
  assign m_expire = m_s2[4] && (m_dwell + 1 == DWL);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0;
      m_stable <= 1'b0; m_stable_old <= 1'b0;
      m_run <= 0; m_dwell <= 0;
      m_step <= 1'b0; m_op <= 2'd0; m_led <= 4'd0;
    end else begin
      m_s1 <= {auto, btn, sw};
      m_s2 <= m_s1;
      if (m_s2[3] != m_stable) begin
        if (m_run + 1 == DEB) begin
          m_stable <= m_s2[3];
          m_run    <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      m_stable_old <= m_stable;
      m_dwell <= (!m_s2[4] || m_press || m_expire) ? 0 : m_dwell + 1;
      m_step  <= m_press || m_expire;
      m_op    <= m_op + {1'b0, m_step};
      m_led   <= gate(m_op, m_s2[2:0]) ? (4'b0001 << m_op) : 4'd0;
    end
  end

  // Compare against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_led", int'(led), int'(m_led));
      check("cyc_op_sel", int'(op_sel), int'(m_op));
      check("cyc_step", int'(step), int'(m_step));
      check("step_width", int'(step & prev_step), 0);
      if (step) n_steps++;
    end
    prev_step <= step;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (DEB + 4) tick();
    btn = 1'b0;
    repeat (DEB + 4) tick();
  endtask

  logic [7:0] tt [4];
  int cur_op;
  int n0;
  logic [3:0] exp_led;

  initial begin
    tt[0] = 8'b0101_0101;
    tt[1] = 8'b1110_1110;
    tt[2] = 8'b0110_0110;
    tt[3] = 8'b1111_1110;

    rst = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_op_sel", int'(op_sel), 0);
    check("rst_led", int'(led), 0);
    check("rst_step", int'(step), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_led", int'(led), 4'b0001);

    // glitches: high 3, low 2, high 3
    n0 = n_steps;
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (2) tick();
    btn = 1'b1; repeat (3) tick();
    btn = 1'b0; repeat (10) tick();
    check("glitch_steps", n_steps - n0, 0);
    check("glitch_op", int'(op_sel), 0);

    // clean press held long: one step after edge 7, advance after edge 8
    n0 = n_steps;
    btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("press_step_e%0d", k), int'(step), (k == 7) ? 1 : 0);
      check($sformatf("press_op_e%0d", k), int'(op_sel), (k >= 8) ? 1 : 0);
    end
    repeat (20) tick();
    btn = 1'b0;
    repeat (10) tick();
    check("hold_one_step", n_steps - n0, 1);
    cur_op = 1;

    // gate truth sweep on every operation
    for (int i = 0; i < 4; i++) begin
      check("sweep_op", int'(op_sel), cur_op);
      check("model_op", int'(m_op), cur_op);
      for (int s = 0; s < 8; s++) begin
        sw = 3'(s);
        repeat (3) tick();
        exp_led = tt[cur_op][s] ? (4'b0001 << cur_op) : 4'd0;
        check($sformatf("truth_op%0d_sw%0d", cur_op, s), int'(led), int'(exp_led));
      end
      press();
      cur_op = (cur_op + 1) % 4;
    end
    sw = 3'd0;

    // asynchronous reset mid-run with op_sel = 2
    press();
    check("pre_rst_op", int'(op_sel), 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_op", int'(op_sel), 0);
    check("async_rst_led", int'(led), 0);
    check("async_rst_step", int'(step), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_led", int'(led), 4'b0001);

    // wrap: four presses from reset
    for (int i = 0; i < 4; i++) begin
      press();
      check($sformatf("wrap_%0d", i), int'(op_sel), (i + 1) % 4);
    end
    cur_op = 0;

    // auto stepping every 5 cycles
    auto = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("auto_step_e%0d", k), int'(step),
            (k == 7 || k == 12 || k == 17) ? 1 : 0);
    end
    auto = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("auto_off_e%0d", k), int'(step), 0);
    end
    auto = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("auto_re_e%0d", k), int'(step),
            (k == 7 || k == 12) ? 1 : 0);
    end
    auto = 1'b0;
    cur_op = (cur_op + 5) % 4;
    repeat (6) tick();
    check("auto_op", int'(op_sel), cur_op);

    // press aligned with dwell expiry: one step, dwell restarts
    btn  = 1'b1;
    auto = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("coll_step_e%0d", k), int'(step),
            (k == 7 || k == 12) ? 1 : 0);
      if (k >= 8) check($sformatf("coll_op_e%0d", k), int'(op_sel), (cur_op + 1) % 4);
    end
    auto = 1'b0;
    tick();
    check("coll_op_final", int'(op_sel), (cur_op + 2) % 4);
    btn = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
